// File: rtl/bit_reverse_printer_pkg.sv
// ============================================================================
// Module   : bit_reverse_printer_pkg
// Purpose  : Shared types and ASCII constants for the bit-string printer.
//            Holds the two-state FSM encoding and the character codes the
//            block recognises on receive and emits on transmit.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bit_reverse_printer_pkg;

  // Two-state controller: gather bit characters, then print them back.
  typedef enum logic [0:0] {
    COLLECT = 1'b0,
    PRINT   = 1'b1
  } state_t;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

endpackage

`default_nettype wire

// File: rtl/bit_reverse_printer_if.sv
// ============================================================================
// Module   : bit_reverse_printer_if
// Purpose  : Bundles the UART-side receive/transmit handshake and the
//            captured-value result of bit_reverse_printer.
// Ports    : master - drives rx_data/new_rx_data/tx_busy/rev_en,
//                     observes tx_data/new_tx_data/bits_out/bits_valid
//            slave  - the printer itself (opposite directions)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bit_reverse_printer_if #(
  parameter int NBITS = 8
);

  logic [7:0]       rx_data;
  logic             new_rx_data;
  logic             tx_busy;
  logic             rev_en;
  logic [7:0]       tx_data;
  logic             new_tx_data;
  logic [NBITS-1:0] bits_out;
  logic             bits_valid;

  modport master (
    output rx_data, new_rx_data, tx_busy, rev_en,
    input  tx_data, new_tx_data, bits_out, bits_valid
  );

  modport slave (
    input  rx_data, new_rx_data, tx_busy, rev_en,
    output tx_data, new_tx_data, bits_out, bits_valid
  );

endinterface

`default_nettype wire

// File: rtl/bit_reverse_printer.sv
// ============================================================================
// Module   : bit_reverse_printer
// Purpose  : Collects up to NBITS '0'/'1' characters from a UART receiver,
//            then prints them back (reversed or in entry order) followed by
//            CR LF, and reports the printed string as a binary value.
//            A string ends on CR (with at least one bit) or when NBITS bits
//            have been captured.
// Ports    : clk  - clock, rising edge
//            rst  - asynchronous reset, active low
//            bus  - bit_reverse_printer_if.slave
//                   rx_data/new_rx_data : received byte + strobe
//                   tx_busy             : transmitter busy
//                   rev_en              : 1 = print reversed
//                   tx_data/new_tx_data : transmit byte + strobe (registered)
//                   bits_out/bits_valid : printed value + update pulse
// Options  : BIT_REVERSE_PRINTER_ECHO_EN - echo each accepted bit character
//            while collecting.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_reverse_printer #(
  parameter int NBITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  bit_reverse_printer_if.slave  bus
);

  import bit_reverse_printer_pkg::*;

  localparam int CW = $clog2(NBITS + 1);  // count: 0..NBITS
  localparam int IW = $clog2(NBITS + 2);  // print index: 0..NBITS+1

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    count;
  logic [NBITS-1:0] cap;
  logic [IW-1:0]    idx;
  logic             rev;

  logic             rx_bit;
  logic             cr_ok;
  logic             full;
  logic             accept_bit;
  logic             go;
  logic             print_fire;
  logic             print_last;
  logic             tx_strobe;
  logic [7:0]       tx_byte;
  logic [7:0]       print_char;
  logic             cur_bit;
  logic [IW-1:0]    cnt_ext;
  logic [IW-1:0]    sel;
  logic [NBITS-1:0] cap_flip;
  logic [NBITS-1:0] entry_bits;
  logic [CW-1:0]    flip_shift;

  assign rx_bit  = bus.new_rx_data && ((bus.rx_data == CH_0) || (bus.rx_data == CH_1));
  assign cr_ok   = bus.new_rx_data && (bus.rx_data == CH_CR) && (count != '0);
  assign full    = (count == CW'(NBITS));
  assign cnt_ext = IW'(count);

  // New bytes may only go out when the previous cycle carried no strobe.
  assign print_fire = (state == PRINT) && !bus.tx_busy && !bus.new_tx_data;
  assign print_last = (idx == cnt_ext + IW'(1));

`ifdef BIT_REVERSE_PRINTER_ECHO_EN
  logic       echo_pend;
  logic [7:0] echo_byte;
  logic       go_req;
  logic       echo_fire;

  // A CR seen while an echo is still queued is remembered in go_req so the
  // print starts only after the echo has left.
  assign accept_bit = (state == COLLECT) && rx_bit && !full && !go_req;
  assign go         = (state == COLLECT) && !echo_pend && (go_req || cr_ok || full);
  assign echo_fire  = (state == COLLECT) && echo_pend && !bus.tx_busy && !bus.new_tx_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      echo_pend <= 1'b0;
      echo_byte <= 8'h00;
      go_req    <= 1'b0;
    end else begin
      if (accept_bit) begin
        echo_pend <= 1'b1;
        echo_byte <= bus.rx_data;
      end else if (echo_fire) begin
        echo_pend <= 1'b0;
      end
      if (go)
        go_req <= 1'b0;
      else if ((state == COLLECT) && cr_ok)
        go_req <= 1'b1;
    end
  end
`else
  assign accept_bit = (state == COLLECT) && rx_bit && !full;
  assign go         = (state == COLLECT) && (cr_ok || full);
`endif

  // Character for the current print position. Reversed order walks the
  // capture from the top filled bit downwards.
  always_comb begin
    sel     = rev ? (cnt_ext - IW'(1) - idx) : idx;
    cur_bit = |(cap & (NBITS'(1) << sel));
    if (idx < cnt_ext)
      print_char = cur_bit ? CH_1 : CH_0;
    else if (idx == cnt_ext)
      print_char = CH_CR;
    else
      print_char = CH_LF;
  end

  // Value loaded into bits_out: first printed character lands in the MSB
  // of the count-bit field. Reversed printing starts at cap[count-1], so the
  // capture register already has that layout; entry order needs the capture
  // mirrored and then aligned down to the count-bit field.
  always_comb begin
    for (int i = 0; i < NBITS; i++)
      cap_flip[NBITS-1-i] = cap[i];
    flip_shift = CW'(NBITS) - count;
    entry_bits = bus.rev_en ? cap : (cap_flip >> flip_shift);
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= COLLECT;
    else
      state <= state_next;
  end

  // FSM: next-state logic
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (go) state_next = PRINT;
      PRINT:   if (print_fire && print_last) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // FSM: output selection for the transmit port
  always_comb begin
    tx_strobe = 1'b0;
    tx_byte   = print_char;
    if (print_fire) begin
      tx_strobe = 1'b1;
    end
`ifdef BIT_REVERSE_PRINTER_ECHO_EN
    else if (echo_fire) begin
      tx_strobe = 1'b1;
      tx_byte   = echo_byte;
    end
`endif
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count           <= '0;
      cap             <= '0;
      idx             <= '0;
      rev             <= 1'b0;
      bus.tx_data     <= 8'h00;
      bus.new_tx_data <= 1'b0;
      bus.bits_out    <= '0;
      bus.bits_valid  <= 1'b0;
    end else begin
      bus.new_tx_data <= tx_strobe;
      if (tx_strobe)
        bus.tx_data <= tx_byte;

      bus.bits_valid <= go;
      if (go) begin
        bus.bits_out <= entry_bits;
        rev          <= bus.rev_en;
        idx          <= '0;
      end

      if (accept_bit) begin
        if (bus.rx_data == CH_1)
          cap <= cap | (NBITS'(1) << count);
        count <= count + CW'(1);
      end

      if (print_fire) begin
        if (print_last) begin
          idx   <= '0;
          count <= '0;
          cap   <= '0;
        end else begin
          idx <= idx + IW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_reverse_printer.sv
// ============================================================================
// Module   : tb_bit_reverse_printer
// Purpose  : Directed self-checking bench for bit_reverse_printer (NBITS=8,
//            default build). Types bit strings, collects the transmitted
//            bytes and the reported value, and compares against
//            hand-computed expectations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_reverse_printer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  bit_reverse_printer_if #(.NBITS(8)) bus ();

  bit_reverse_printer #(.NBITS(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Transmit / result monitor
  logic [7:0] txq[$];
  int         n_strobe  = 0;
  int         n_valid   = 0;
  logic [7:0] last_bits = 8'h00;

  always @(negedge clk) begin
    if (bus.new_tx_data === 1'b1) begin
      txq.push_back(bus.tx_data);
      n_strobe <= n_strobe + 1;
    end
    if (bus.bits_valid === 1'b1) begin
      n_valid   <= n_valid + 1;
      last_bits <= bus.bits_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data     = b;
    bus.new_rx_data = 1'b1;
    @(posedge clk); #1;
    bus.new_rx_data = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++)
      send(s[i]);
  endtask

  task automatic wait_bytes(input int n);
    int cyc;
    cyc = 0;
    while (txq.size() < n && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_print(input string tag, input string exp, input logic [7:0] exp_bits,
                             input int v0);
    int         n;
    logic [7:0] e;
    n = exp.len() + 2;
    wait_bytes(n);
    repeat (12) @(negedge clk);
    #1;
    chk({tag, " len"}, txq.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < exp.len())       e = exp[i];
      else if (i == exp.len()) e = 8'h0D;
      else                     e = 8'h0A;
      chk($sformatf("%s byte%0d", tag, i),
          (i < txq.size()) ? {24'h0, txq[i]} : 32'hFFFF_FFFF, {24'h0, e});
    end
    chk({tag, " bits_out"}, {24'h0, last_bits}, {24'h0, exp_bits});
    chk({tag, " bits_valid pulses"}, n_valid - v0, 1);
    txq.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int snap;
    int sz;

    bus.rx_data     = 8'h00;
    bus.new_rx_data = 1'b0;
    bus.tx_busy     = 1'b0;
    bus.rev_en      = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("reset tx_data",     {24'h0, bus.tx_data}, 0);
    chk("reset new_tx_data", {31'h0, bus.new_tx_data}, 0);
    chk("reset bits_out",    {24'h0, bus.bits_out}, 0);
    chk("reset bits_valid",  {31'h0, bus.bits_valid}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Full string, reversed
    v0 = n_valid;
    bus.rev_en = 1'b1;
    send_str("10110000");
    check_print("rev8", "00001101", 8'h0D, v0);

    // Full string, entry order
    v0 = n_valid;
    bus.rev_en = 1'b0;
    send_str("10110000");
    check_print("fwd8", "10110000", 8'hB0, v0);

    // Short string terminated by CR, reversed
    v0 = n_valid;
    bus.rev_en = 1'b1;
    send_str("1011");
    send(8'h0D);
    check_print("cr4", "1101", 8'h0D, v0);

    // Leading CR ignored, non-bit characters filtered
    v0 = n_valid;
    bus.rev_en = 1'b0;
    send(8'h0D);
    send_str("1x2 0");
    repeat (30) @(negedge clk);
    #1;
    chk("filter no tx", txq.size(), 0);
    chk("filter no valid", n_valid - v0, 0);
    send_str("000000");
    check_print("filter", "10000000", 8'h80, v0);

    // Stall mid-print; rx dropped; rev_en changes ignored until next print
    v0 = n_valid;
    bus.rev_en = 1'b1;
    send_str("11001010");
    wait_bytes(3);
    bus.tx_busy = 1'b1;
    bus.rev_en  = 1'b0;
    @(negedge clk); #1;
    snap = n_strobe;
    send(8'h31);
    send(8'h31);
    send(8'h0D);
    repeat (43) @(negedge clk);
    #1;
    chk("busy no strobe", n_strobe, snap);
    bus.tx_busy = 1'b0;
    check_print("stall", "01010011", 8'h53, v0);
    v0 = n_valid;
    send(8'h0D);
    repeat (20) @(negedge clk);
    #1;
    chk("dropped rx no print", txq.size(), 0);
    chk("dropped rx no valid", n_valid - v0, 0);

    // Reset in the middle of a print
    bus.rev_en = 1'b0;
    send_str("10110000");
    wait_bytes(3);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("midrst tx_data",     {24'h0, bus.tx_data}, 0);
    chk("midrst new_tx_data", {31'h0, bus.new_tx_data}, 0);
    chk("midrst bits_out",    {24'h0, bus.bits_out}, 0);
    chk("midrst bits_valid",  {31'h0, bus.bits_valid}, 0);
    sz = txq.size();
    chk("midrst partial", (sz >= 3 && sz < 10) ? 1 : 0, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    chk("abort no strobes", txq.size(), sz);
    txq.delete();
    v0 = n_valid;
    bus.rev_en = 1'b1;
    send_str("11111111");
    check_print("after rst", "11111111", 8'hFF, v0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
